// File: rtl/decode_execute_stage_pkg.sv
// Shared VTX1 pipeline definitions for the decode->execute stage.
// Provides the machine word/register widths and the stage_state encoding
// reported on the stage_state status port.
package decode_execute_stage_pkg;

    localparam int VTX1_WORD_WIDTH     = 36;
    localparam int VTX1_REG_ADDR_WIDTH = 5;
    localparam int VTX1_OP_WIDTH       = 8;
    localparam int VTX1_STALL_TIMEOUT  = 15;

    typedef enum logic [1:0] {
        STAGE_RUN        = 2'b00,
        STAGE_HOLD       = 2'b01,
        STAGE_LOAD_STALL = 2'b10,
        STAGE_FLUSH      = 2'b11
    } stage_state_e;

endpackage

// File: rtl/decode_execute_stage_if.sv
// Decode->execute bundle interface.
// master: decode/forwarding side (drives dec_*, fwd_*, load_fwd_stall, flush, ex_ready)
// slave : the pipeline register (drives dec_ready and all ex_* fields)
interface decode_execute_stage_if
    import decode_execute_stage_pkg::*;
#(
    parameter int WORD_W     = VTX1_WORD_WIDTH,
    parameter int REG_ADDR_W = VTX1_REG_ADDR_WIDTH,
    parameter int OP_W       = VTX1_OP_WIDTH
) ();

    // decode side
    logic                  dec_valid;
    logic                  dec_ready;
    logic [OP_W-1:0]       dec_opcode;
    logic [WORD_W-1:0]     dec_imm;
    logic [REG_ADDR_W-1:0] dec_rd1;
    logic [REG_ADDR_W-1:0] dec_rd2;
    logic                  dec_wr_en1;
    logic                  dec_wr_en2;
    logic                  dec_mem_read;
    logic [WORD_W-1:0]     fwd_data_a;
    logic [WORD_W-1:0]     fwd_data_b;
    logic [WORD_W-1:0]     fwd_data_c;
    logic                  load_fwd_stall;
    logic                  flush;

    // execute side
    logic                  ex_ready;
    logic                  ex_valid;
    logic [OP_W-1:0]       ex_opcode;
    logic [WORD_W-1:0]     ex_imm;
    logic [WORD_W-1:0]     ex_op_a;
    logic [WORD_W-1:0]     ex_op_b;
    logic [WORD_W-1:0]     ex_op_c;
    logic [REG_ADDR_W-1:0] ex_rd1;
    logic [REG_ADDR_W-1:0] ex_rd2;
    logic                  ex_wr_en1;
    logic                  ex_wr_en2;
    logic                  ex_mem_read;

    modport master (
        output dec_valid, dec_opcode, dec_imm, dec_rd1, dec_rd2, dec_wr_en1, dec_wr_en2,
               dec_mem_read, fwd_data_a, fwd_data_b, fwd_data_c, load_fwd_stall, flush, ex_ready,
        input  dec_ready, ex_valid, ex_opcode, ex_imm, ex_op_a, ex_op_b, ex_op_c, ex_rd1, ex_rd2,
               ex_wr_en1, ex_wr_en2, ex_mem_read
    );

    modport slave (
        input  dec_valid, dec_opcode, dec_imm, dec_rd1, dec_rd2, dec_wr_en1, dec_wr_en2,
               dec_mem_read, fwd_data_a, fwd_data_b, fwd_data_c, load_fwd_stall, flush, ex_ready,
        output dec_ready, ex_valid, ex_opcode, ex_imm, ex_op_a, ex_op_b, ex_op_c, ex_rd1, ex_rd2,
               ex_wr_en1, ex_wr_en2, ex_mem_read
    );

endinterface

// File: rtl/decode_execute_stage_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
// Ports: clk, rst_n (async low, loads INIT), inc (count enable), q (count value).
// Holds at all-ones once reached.
module sat_counter #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= INIT;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode->execute pipeline register of the VTX1 VLIW pipeline.
// Latches forwarded operands and decoded control for one bundle, bubbles on
// load-use stall, holds on execute back-pressure, kills contents on flush.
// Ports: clk, rst_n (async low); bus (slave modport: dec_* in / dec_ready out,
// fwd_data_a/b/c, load_fwd_stall, flush, ex_ready in / ex_* out);
// stage_state, stall_timeout (sticky), bubble/hold/flush perf counters.
module decode_execute_stage
    import decode_execute_stage_pkg::*;
#(
    parameter int WORD_W        = VTX1_WORD_WIDTH,
    parameter int REG_ADDR_W    = VTX1_REG_ADDR_WIDTH,
    parameter int OP_W          = VTX1_OP_WIDTH,
    parameter int STALL_TIMEOUT = VTX1_STALL_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decode_execute_stage_if.slave bus,
    output stage_state_e          stage_state,
    output logic                  stall_timeout,
    output logic [31:0]           bubble_count,
    output logic [31:0]           hold_count,
    output logic [31:0]           flush_count
);

    localparam int STALL_CNT_W = $clog2(STALL_TIMEOUT + 1);

    stage_state_e           state_nxt;
    logic                   advance;
    logic                   dec_ready;
    logic                   capture;
    logic                   bubble_inc;
    logic                   hold_inc;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign bus.dec_ready = dec_ready;

    always_comb begin
        advance    = !bus.ex_valid || bus.ex_ready;
        // The FLUSH cycle itself refuses decode so the killed bundle's successor
        // is not captured from a stale decode slot.
        dec_ready  = advance && !bus.load_fwd_stall && !bus.flush && (stage_state != STAGE_FLUSH);
        capture    = bus.dec_valid && dec_ready;
        // Only bubbles caused by the load-use hazard are counted; flush wins.
        bubble_inc = advance && bus.dec_valid && bus.load_fwd_stall && !bus.flush;

        state_nxt = STAGE_RUN;
        if (bus.flush)
            state_nxt = STAGE_FLUSH;
        else if (bus.ex_valid && !bus.ex_ready)
            state_nxt = STAGE_HOLD;
        else if (bus.dec_valid && bus.load_fwd_stall)
            state_nxt = STAGE_LOAD_STALL;
        hold_inc = (state_nxt == STAGE_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_state <= STAGE_RUN;
        else
            stage_state <= state_nxt;
    end

    // Bundle register. Data fields may stay stale across a bubble; only the
    // side-effect bits (valid, write enables, mem_read) are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_opcode   <= '0;
            bus.ex_imm      <= '0;
            bus.ex_op_a     <= '0;
            bus.ex_op_b     <= '0;
            bus.ex_op_c     <= '0;
            bus.ex_rd1      <= '0;
            bus.ex_rd2      <= '0;
            bus.ex_wr_en1   <= 1'b0;
            bus.ex_wr_en2   <= 1'b0;
            bus.ex_mem_read <= 1'b0;
        end else if (bus.flush || (advance && !capture)) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_wr_en1   <= 1'b0;
            bus.ex_wr_en2   <= 1'b0;
            bus.ex_mem_read <= 1'b0;
        end else if (capture) begin
            bus.ex_valid    <= 1'b1;
            bus.ex_opcode   <= bus.dec_opcode;
            bus.ex_imm      <= bus.dec_imm;
            bus.ex_op_a     <= bus.fwd_data_a;
            bus.ex_op_b     <= bus.fwd_data_b;
            bus.ex_op_c     <= bus.fwd_data_c;
            bus.ex_rd1      <= bus.dec_rd1;
            bus.ex_rd2      <= bus.dec_rd2;
            bus.ex_wr_en1   <= bus.dec_wr_en1;
            bus.ex_wr_en2   <= bus.dec_wr_en2;
            bus.ex_mem_read <= bus.dec_mem_read;
        end
    end

    // Consecutive load-stall watchdog: counts edges that land in LOAD_STALL,
    // so an N-cycle stall leaves the counter at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (state_nxt == STAGE_LOAD_STALL) begin
            if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_CNT_W'(STALL_TIMEOUT - 1))
                stall_timeout <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    sat_counter #(.WIDTH(32)) u_bubble_cnt (.clk(clk), .rst_n(rst_n), .inc(bubble_inc), .q(bubble_count));
    sat_counter #(.WIDTH(32)) u_hold_cnt   (.clk(clk), .rst_n(rst_n), .inc(hold_inc),   .q(hold_count));
    sat_counter #(.WIDTH(32)) u_flush_cnt  (.clk(clk), .rst_n(rst_n), .inc(bus.flush),  .q(flush_count));

endmodule
